// File: rtl/vga_sprite_engine_if.sv
// Sprite-in / video-out bundle for vga_sprite_engine.
interface vga_sprite_engine_if #(parameter int N_SPR = 3);
   typedef struct packed {
      logic [N_SPR*10-1:0] x;
      logic [N_SPR*10-1:0] y;
      logic [N_SPR-1:0]    en;
      logic [N_SPR*24-1:0] rgb;
   } spr_req_t;

   logic [N_SPR*10-1:0] spr_x;
   logic [N_SPR*10-1:0] spr_y;
   logic [N_SPR-1:0]    spr_en;
   logic [N_SPR*24-1:0] spr_rgb;
   logic                pix_en;
   logic                hsync;
   logic                vsync;
   logic                video_on;
   logic [7:0]          red;
   logic [7:0]          green;
   logic [7:0]          blue;
   logic                frame_start;
   logic [N_SPR-1:0]    coll_flags;

   modport master (
      output spr_x, spr_y, spr_en, spr_rgb,
      input  pix_en, hsync, vsync, video_on, red, green, blue, frame_start, coll_flags
   );
   modport slave (
      input  spr_x, spr_y, spr_en, spr_rgb,
      output pix_en, hsync, vsync, video_on, red, green, blue, frame_start, coll_flags
   );
endinterface

// File: rtl/vga_sprite_engine.sv
// VGA timing generator + N_SPR rectangular sprite compositor, 2-stage pixel pipeline.
// Optional build macro SPRITE_COLLISION_EN adds per-frame sprite collision flags.

module vga_spr_hit #(
   parameter int SPR_W = 64,
   parameter int SPR_H = 96
) (
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic [9:0] sx,
   input  logic [9:0] sy,
   input  logic       en,
   output logic       hit
);
   logic [10:0] xe, ye;

   // 11-bit bounds so sprites near the right/bottom edge clip instead of wrapping
   assign xe  = {1'b0, sx} + 11'(SPR_W);
   assign ye  = {1'b0, sy} + 11'(SPR_H);
   assign hit = en && (x >= sx) && ({1'b0, x} < xe) && (y >= sy) && ({1'b0, y} < ye);
endmodule

module vga_sprite_engine #(
   parameter int          CLK_DIV  = 2,
   parameter int          H_ACTIVE = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33,
   parameter int          N_SPR    = 3,
   parameter int          SPR_W    = 64,
   parameter int          SPR_H    = 96,
   parameter logic [23:0] BG_RGB   = 24'h404040
) (
   input logic                clock,
   input logic                rst_n,
   vga_sprite_engine_if.slave bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_BEG  = H_ACTIVE + H_FP;
   localparam int HS_END  = HS_BEG + H_SYNC;
   localparam int VS_BEG  = V_ACTIVE + V_FP;
   localparam int VS_END  = VS_BEG + V_SYNC;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef struct packed {
      logic vis;
      logic hs;
      logic vs;
   } ctl_t;

   localparam ctl_t CTL_RST = '{vis: 1'b0, hs: 1'b1, vs: 1'b1};

   logic [DW-1:0]             div;
   logic                      pe, sample;
   logic [9:0]                h_cnt, v_cnt;
   logic [N_SPR-1:0][9:0]     sh_x, sh_y;
   logic [N_SPR-1:0]          sh_en;
   logic [N_SPR-1:0][23:0]    sh_rgb;
   logic [N_SPR-1:0]          hit, s1_hit;
   ctl_t                      raw_ctl, s1_ctl, s2_ctl;
   logic [23:0]               mux_rgb, rgb_q;

   assign pe     = (div == DW'(CLK_DIV - 1));
   assign sample = pe && (h_cnt == '0) && (v_cnt == 10'(V_ACTIVE));

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)  div <= '0;
      else if (pe) div <= '0;
      else         div <= div + DW'(1);
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pe) begin
         if (h_cnt == 10'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   // Sprite state is only taken at the first blank line so a frame never tears
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         sh_x   <= '0;
         sh_y   <= '0;
         sh_en  <= '0;
         sh_rgb <= '0;
      end else if (sample) begin
         for (int i = 0; i < N_SPR; i++) begin
            sh_x[i]   <= bus.spr_x[10*i +: 10];
            sh_y[i]   <= bus.spr_y[10*i +: 10];
            sh_rgb[i] <= bus.spr_rgb[24*i +: 24];
         end
         sh_en <= bus.spr_en;
      end
   end

   assign raw_ctl.vis = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
   assign raw_ctl.hs  = !((h_cnt >= 10'(HS_BEG)) && (h_cnt < 10'(HS_END)));
   assign raw_ctl.vs  = !((v_cnt >= 10'(VS_BEG)) && (v_cnt < 10'(VS_END)));

   for (genvar g = 0; g < N_SPR; g++) begin : g_lane
      vga_spr_hit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
         .x   (h_cnt),
         .y   (v_cnt),
         .sx  (sh_x[g]),
         .sy  (sh_y[g]),
         .en  (sh_en[g]),
         .hit (hit[g])
      );
   end

   // Walk from highest index down so the lowest-index hit lands last and wins
   always_comb begin
      mux_rgb = BG_RGB;
      for (int i = N_SPR - 1; i >= 0; i--)
         if (s1_hit[i]) mux_rgb = sh_rgb[i];
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         s1_hit <= '0;
         s1_ctl <= CTL_RST;
         s2_ctl <= CTL_RST;
         rgb_q  <= '0;
      end else if (pe) begin
         s1_hit <= hit;
         s1_ctl <= raw_ctl;
         s2_ctl <= s1_ctl;
         rgb_q  <= s1_ctl.vis ? mux_rgb : 24'h0;
      end
   end

   assign bus.pix_en      = pe;
   assign bus.frame_start = sample;
   assign bus.hsync       = s2_ctl.hs;
   assign bus.vsync       = s2_ctl.vs;
   assign bus.video_on    = s2_ctl.vis;
   assign bus.red         = rgb_q[23:16];
   assign bus.green       = rgb_q[15:8];
   assign bus.blue        = rgb_q[7:0];

`ifdef SPRITE_COLLISION_EN
   logic [N_SPR-1:0] coll_acc, coll_q;
   logic             multi;

   // x & (x-1) is nonzero exactly when two or more bits are set
   assign multi = |(s1_hit & (s1_hit - 1'b1));

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         coll_acc <= '0;
         coll_q   <= '0;
      end else if (pe) begin
         if (sample) begin
            coll_q   <= coll_acc;
            coll_acc <= '0;
         end else if (s1_ctl.vis && multi) begin
            coll_acc <= coll_acc | s1_hit;
         end
      end
   end

   assign bus.coll_flags = coll_q;
`else
   assign bus.coll_flags = '0;
`endif
endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine on a shrunken 64x30 raster (48x24 visible, 8x6 sprites).
module tb_vga_sprite_engine;
   localparam int HT = 64;
   localparam int VT = 30;
   localparam int FR = HT * VT;
   localparam logic [23:0] BG  = 24'h404040;
   localparam logic [23:0] RED = 24'hFF0000;
   localparam logic [23:0] GRN = 24'h00FF00;
   localparam logic [23:0] BLU = 24'h0000FF;
`ifdef SPRITE_COLLISION_EN
   localparam logic [2:0] COLL_EXP = 3'b011;
`else
   localparam logic [2:0] COLL_EXP = 3'b000;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   int   sidx = -1;

   always #5 clk = ~clk;

   vga_sprite_engine_if #(.N_SPR(3)) bus ();

   vga_sprite_engine #(
      .CLK_DIV(2), .H_ACTIVE(48), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2),
      .N_SPR(3), .SPR_W(8), .SPR_H(6), .BG_RGB(24'h404040)
   ) dut (
      .clock (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to the next negedge at which pix_en is high
   task automatic step();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.pix_en !== 1'b1 && n < 8);
      if (bus.pix_en !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL pix_en_timeout: observed no strobe in 8 clocks, expected one every 2");
         $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
         $fatal(1, "pix_en stalled");
      end
      sidx++;
   endtask

   task automatic to_strobe(input int t);
      while (sidx < t) step();
   endtask

   function automatic int pidx(input int f, input int x, input int y);
      return f * FR + y * HT + x;
   endfunction

   // RGB of pixel n appears two pixel periods later
   task automatic pix(input string tag, input int f, input int x, input int y, input logic [23:0] rgb);
      to_strobe(pidx(f, x, y) + 2);
      chk(tag, {8'h0, bus.red, bus.green, bus.blue}, {8'h0, rgb});
   endtask

   task automatic ctl(input string tag, input int f, input int x, input int y,
                      input logic hs, input logic vs, input logic vo);
      to_strobe(pidx(f, x, y) + 2);
      chk(tag, {29'h0, bus.hsync, bus.vsync, bus.video_on}, {29'h0, hs, vs, vo});
   endtask

   task automatic set_spr(input int i, input int x, input int y, input logic en, input logic [23:0] rgb);
      bus.spr_x[10*i +: 10]   = 10'(x);
      bus.spr_y[10*i +: 10]   = 10'(y);
      bus.spr_en[i]           = en;
      bus.spr_rgb[24*i +: 24] = rgb;
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_ctl"}, {27'h0, bus.hsync, bus.vsync, bus.video_on, bus.frame_start, bus.pix_en},
          32'b11000);
      chk({tag, "_rgb"}, {8'h0, bus.red, bus.green, bus.blue}, 32'h0);
      chk({tag, "_coll"}, {29'h0, bus.coll_flags}, 32'h0);
   endtask

   initial begin
      bus.spr_x = '0; bus.spr_y = '0; bus.spr_en = '0; bus.spr_rgb = '0;
      set_spr(0, 10, 5, 1'b1, RED);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_chk("reset");
      rst_n = 1'b1;
      sidx  = -1;

      to_strobe(0);
      chk("pix_en_hi", {31'h0, bus.pix_en}, 32'h1);
      @(negedge clk);
      chk("pix_en_lo", {31'h0, bus.pix_en}, 32'h0);

      // frame 0: horizontal timing on line 1, no sprite before first sample
      ctl("vo_last_col", 0, 47, 1, 1'b1, 1'b1, 1'b1);
      ctl("vo_blank",    0, 48, 1, 1'b1, 1'b1, 1'b0);
      pix("rgb_blank",   0, 48, 1, 24'h0);
      ctl("hs_pre",      0, 51, 1, 1'b1, 1'b1, 1'b0);
      ctl("hs_first",    0, 52, 1, 1'b0, 1'b1, 1'b0);
      ctl("hs_last",     0, 59, 1, 1'b0, 1'b1, 1'b0);
      ctl("hs_post",     0, 60, 1, 1'b1, 1'b1, 1'b0);
      pix("f0_no_spr",   0, 10, 5, BG);
      to_strobe(pidx(0, 0, 24) - 1);
      chk("fs_before", {31'h0, bus.frame_start}, 32'h0);
      to_strobe(pidx(0, 0, 24));
      chk("fs_pulse", {31'h0, bus.frame_start}, 32'h1);
      ctl("vs_pre",      0, 0, 25, 1'b1, 1'b1, 1'b0);
      ctl("vs_first",    0, 0, 26, 1'b1, 1'b0, 1'b0);
      ctl("vs_last",     0, 63, 27, 1'b1, 1'b0, 1'b0);
      ctl("vs_post",     0, 0, 28, 1'b1, 1'b1, 1'b0);

      // frame 1: sprite 0 at (10,5); inputs change at line 8 without effect
      pix("s0_left_out", 1, 9, 5, BG);
      pix("s0_corner",   1, 10, 5, RED);
      pix("s0_right_out",1, 18, 5, BG);
      to_strobe(pidx(1, 0, 8));
      set_spr(0, 20, 12, 1'b1, RED);
      set_spr(1, 24, 12, 1'b1, GRN);
      set_spr(2, 44, 0, 1'b1, BLU);
      pix("midframe_old",  1, 17, 10, RED);
      pix("s0_below_out",  1, 17, 11, BG);
      pix("midframe_new",  1, 20, 12, BG);

      // frame 2: new positions, edge clipping, priority, overlap
      pix("clip_nowrap0",  2, 0, 1, BG);
      pix("clip_nowrap3",  2, 3, 1, BG);
      pix("s2_left",       2, 44, 1, BLU);
      pix("s2_edge",       2, 47, 1, BLU);
      pix("s2_clipped",    2, 48, 1, 24'h0);
      pix("s0_moved",      2, 10, 5, BG);
      to_strobe(pidx(2, 0, 8));
      set_spr(1, 24, 12, 1'b0, GRN);
      set_spr(2, 44, 0, 1'b0, BLU);
      pix("s0_only",       2, 20, 12, RED);
      pix("overlap_pri",   2, 24, 12, RED);
      pix("overlap_end",   2, 27, 12, RED);
      pix("s1_only",       2, 28, 12, GRN);
      pix("s1_end",        2, 31, 12, GRN);
      pix("s1_after",      2, 32, 12, BG);
      to_strobe(pidx(2, 0, 24) - 6);
      chk("coll_before", {29'h0, bus.coll_flags}, 32'h0);
      to_strobe(pidx(2, 0, 24) + 2);
      chk("coll_set", {29'h0, bus.coll_flags}, {29'h0, COLL_EXP});

      // frame 3: sprites separated, flags clear at next sample
      pix("s1_gone", 3, 28, 12, BG);
      to_strobe(pidx(3, 0, 24) + 2);
      chk("coll_clear", {29'h0, bus.coll_flags}, 32'h0);

      // reset mid-frame at line 15 of frame 4
      to_strobe(pidx(4, 0, 15));
      rst_n = 1'b0;
      #1;
      rst_chk("midreset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      sidx  = -1;
      pix("post_rst_noshadow", 0, 20, 12, BG);
      to_strobe(pidx(0, 0, 24));
      chk("post_rst_fs", {31'h0, bus.frame_start}, 32'h1);
      pix("post_rst_sampled", 1, 20, 12, RED);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
